// File: rtl/nes_pkg.sv
// Shared NES definitions used by the sprite-DMA engine.
// Holds the OAM DMA state encodings, the transfer length and the address of
// the $4014 register that software writes to start a transfer.
package nes_pkg;

    typedef enum logic [2:0] {
        OAM_DMA_IDLE  = 3'd0,
        OAM_DMA_HALT  = 3'd1,
        OAM_DMA_ALIGN = 3'd2,
        OAM_DMA_READ  = 3'd3,
        OAM_DMA_WRITE = 3'd4
    } oam_dma_state_t;

    // Bytes moved per transfer: one full CPU page.
    localparam int OAM_DMA_LEN = 256;

    // CPU address of the sprite-DMA page register.
    localparam logic [15:0] OAM_DMA_REG_ADDR = 16'h4014;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA engine ($4014): copies one 256-byte CPU page into OAM port A.
// Optional feature macro: OAM_DMA_ABORT_EN adds the dma_abort input, which
// returns the engine to IDLE without a done pulse.
//
// Bus timing: every CPU cycle is one clk with ce=1. mem_rd is a one-cycle
// request qualified by ce; the addressed byte must be on mem_din during the
// next ce cycle. oam_we is likewise qualified by ce, so the OAM RAM commits
// the byte on the same clk edge that advances the FSM. A dbg_state output
// mirrors the FSM state for observation.
module oam_dma_ctrl
    import nes_pkg::*;
#(
    parameter int OAM_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int CPU_ADDR_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ce,
    input  logic                      dma_start,
    input  logic [7:0]                dma_page,
    input  logic [OAM_ADDR_WIDTH-1:0] oam_base,
    output logic                      cpu_halt,
    output logic                      mem_rd,
    output logic [CPU_ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_din,
    output logic                      oam_we,
    output logic [OAM_ADDR_WIDTH-1:0] oam_addr,
    output logic [DATA_WIDTH-1:0]     oam_din,
    output logic                      dma_done,
`ifdef OAM_DMA_ABORT_EN
    input  logic                      dma_abort,
`endif
    output oam_dma_state_t            dbg_state
);

    localparam logic [OAM_ADDR_WIDTH-1:0] LAST_INDEX = OAM_ADDR_WIDTH'(OAM_DMA_LEN - 1);

    oam_dma_state_t            r_state;
    logic                      r_parity;
    logic                      r_halt;
    logic                      r_done;
    logic [7:0]                r_page;
    logic [OAM_ADDR_WIDTH-1:0] r_base;
    logic [OAM_ADDR_WIDTH-1:0] r_index;
    logic                      w_abort;

`ifdef OAM_DMA_ABORT_EN
    assign w_abort = dma_abort;
`else
    assign w_abort = 1'b0;
`endif

    // Even/odd CPU cycle tracker; decides whether an alignment cycle is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (ce) begin
            r_parity <= ~r_parity;
        end
    end

    // Transfer FSM: halt, optional align, then 256 read/write pairs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= OAM_DMA_IDLE;
            r_halt  <= 1'b0;
            r_done  <= 1'b0;
            r_page  <= '0;
            r_base  <= '0;
            r_index <= '0;
        end else begin
            // done is a single-clk pulse even when ce is sparse
            r_done <= 1'b0;
            if (ce) begin
                if (w_abort && (r_state != OAM_DMA_IDLE)) begin
                    r_state <= OAM_DMA_IDLE;
                    r_halt  <= 1'b0;
                end else begin
                    case (r_state)
                        OAM_DMA_IDLE: begin
                            // a strobe landing on the done cycle is dropped
                            if (dma_start && !r_done && !w_abort) begin
                                r_state <= OAM_DMA_HALT;
                                r_page  <= dma_page;
                                r_base  <= oam_base;
                                r_index <= '0;
                                r_halt  <= 1'b1;
                            end
                        end
                        OAM_DMA_HALT: begin
                            r_state <= r_parity ? OAM_DMA_ALIGN : OAM_DMA_READ;
                        end
                        OAM_DMA_ALIGN: begin
                            r_state <= OAM_DMA_READ;
                        end
                        OAM_DMA_READ: begin
                            r_state <= OAM_DMA_WRITE;
                        end
                        OAM_DMA_WRITE: begin
                            r_index <= r_index + OAM_ADDR_WIDTH'(1);
                            if (r_index == LAST_INDEX) begin
                                r_state <= OAM_DMA_IDLE;
                                r_done  <= 1'b1;
                                r_halt  <= 1'b0;
                            end else begin
                                r_state <= OAM_DMA_READ;
                            end
                        end
                        default: begin
                            r_state <= OAM_DMA_IDLE;
                            r_halt  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign cpu_halt  = r_halt;
    assign dma_done  = r_done;
    assign dbg_state = r_state;

    assign mem_rd   = ce && (r_state == OAM_DMA_READ);
    assign mem_addr = CPU_ADDR_WIDTH'({r_page, r_index});

    // OAM write happens in the CPU cycle after the read, straight from the bus
    assign oam_we   = ce && (r_state == OAM_DMA_WRITE);
    assign oam_addr = r_base + r_index;
    assign oam_din  = oam_we ? mem_din : '0;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: bus responder, OAM model and a
// scoreboard queue of expected {oam_addr, oam_din} writes.
// Build with +define+OAM_DMA_ABORT_EN to include the abort scenario.
module tb_oam_dma_ctrl;
    import nes_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           ce;
    logic           dma_start;
    logic [7:0]     dma_page;
    logic [7:0]     oam_base;
    logic           cpu_halt;
    logic           mem_rd;
    logic [15:0]    mem_addr;
    logic [7:0]     mem_din;
    logic           oam_we;
    logic [7:0]     oam_addr;
    logic [7:0]     oam_din;
    logic           dma_done;
`ifdef OAM_DMA_ABORT_EN
    logic           dma_abort;
`endif
    oam_dma_state_t dbg_state;

    oam_dma_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .dma_start (dma_start),
        .dma_page  (dma_page),
        .oam_base  (oam_base),
        .cpu_halt  (cpu_halt),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .oam_we    (oam_we),
        .oam_addr  (oam_addr),
        .oam_din   (oam_din),
        .dma_done  (dma_done),
`ifdef OAM_DMA_ABORT_EN
        .dma_abort (dma_abort),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- models / scoreboard ----------------
    logic [7:0]  mem_m [65536];
    logic [7:0]  oam_m [256];
    logic [7:0]  wr_addr [256];
    logic [15:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_ce     = 0;
    int xfer_ce  = 0;
    int done_cnt = 0;
    int done_at  = -1;
    int halt_err = 0;
    int gate_err = 0;
    int write_cnt = 0;
    int extra_wr = 0;
    bit in_xfer  = 1'b0;
    bit saw_align = 1'b0;

    // CPU bus responder: data for a read appears for the next CPU cycle
    initial mem_din = 8'h00;
    always @(posedge clk) begin
        if (ce === 1'b1 && mem_rd === 1'b1) mem_din <= mem_m[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One clk: drive at negedge, sample 2ns later, edge follows at +5.
    task automatic step(input bit ce_v, input bit start_v, input bit abort_v);
        logic [15:0] e;
        @(negedge clk);
        ce        = ce_v;
        dma_start = start_v;
`ifdef OAM_DMA_ABORT_EN
        dma_abort = abort_v;
`else
        if (abort_v) extra_wr = extra_wr + 0;
`endif
        #2;
        if (!ce_v && (oam_we !== 1'b0 || mem_rd !== 1'b0)) gate_err++;
        if (oam_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                extra_wr++;
            end else begin
                e = exp_q.pop_front();
                check("oam_write", {16'h0, oam_addr, oam_din}, {16'h0, e});
            end
            if (write_cnt < 256) wr_addr[write_cnt] = oam_addr;
            write_cnt++;
            oam_m[oam_addr] = oam_din;
        end
        if (dma_done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = xfer_ce;
        end
        if (in_xfer && done_cnt == 0 && cpu_halt !== 1'b1) halt_err++;
        if (dbg_state == OAM_DMA_ALIGN) saw_align = 1'b1;
        if (ce_v) begin
            n_ce++;
            xfer_ce++;
        end
    endtask

    // Full transfer scenario. stop_at_byte >= 0 ends the run after that many
    // writes (for reset) or aborts there (do_abort).
    task automatic run_xfer(input logic [7:0] page, input logic [7:0] base, input bit odd,
                            input int ce_div, input int mid_start_at, input bit start_on_done,
                            input int stop_at_byte, input bit do_abort, input string tag);
        int total;
        int nexp;
        int c;
        bit ce_v;
        bit st;
        bit ab;
        bit mid_sent;
        bit done_sent;
        bit ab_sent;
        total = odd ? 514 : 513;
        // trigger edge parity = (n_ce+1) mod 2, seen by HALT
        if (((n_ce + 1) % 2) != int'(odd)) step(1'b1, 1'b0, 1'b0);
        nexp = (stop_at_byte >= 0) ? stop_at_byte : 256;
        exp_q.delete();
        for (int i = 0; i < nexp; i++) begin
            exp_q.push_back({base + 8'(i), mem_m[{page, 8'(i)}]});
        end
        dma_page = page;
        oam_base = base;
        done_cnt = 0; done_at = -1; halt_err = 0; gate_err = 0;
        write_cnt = 0; extra_wr = 0; saw_align = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        in_xfer = 1'b1;
        xfer_ce = 0;
        c = 0; mid_sent = 1'b0; done_sent = 1'b0; ab_sent = 1'b0;
        while (c < 6000) begin
            ce_v = (ce_div == 0) ? 1'($urandom_range(0, 1)) : ((c % ce_div) == (ce_div - 1));
            st = 1'b0;
            ab = 1'b0;
            if (mid_start_at >= 0 && xfer_ce == mid_start_at && !mid_sent) begin
                ce_v = 1'b1; st = 1'b1; mid_sent = 1'b1;
            end
            if (start_on_done && xfer_ce == total && !done_sent) begin
                ce_v = 1'b1; st = 1'b1; done_sent = 1'b1;
            end
            if (do_abort && write_cnt == stop_at_byte && !ab_sent) begin
                ce_v = 1'b1; ab = 1'b1; ab_sent = 1'b1;
            end
            step(ce_v, st, ab);
            c++;
            if (ab_sent) break;
            if (stop_at_byte >= 0 && !do_abort && write_cnt == stop_at_byte) break;
            if (done_cnt > 0) break;
        end
        if (c >= 6000) check({tag, "_timeout"}, c, 0);
        if (stop_at_byte >= 0 && !do_abort) return;
        in_xfer = 1'b0;
        if (do_abort) begin
            step(1'b0, 1'b0, 1'b0);
            check({tag, "_halt_dropped"}, cpu_halt, 1'b0);
        end
        for (int k = 0; k < 12; k++) step(k[0], 1'b0, 1'b0);
        check({tag, "_state_idle"}, dbg_state, OAM_DMA_IDLE);
        check({tag, "_halt_low"}, cpu_halt, 1'b0);
        check({tag, "_gate"}, gate_err, 0);
        check({tag, "_extra_writes"}, extra_wr, 0);
        check({tag, "_exp_left"}, exp_q.size(), 0);
        check({tag, "_halt_held"}, halt_err, 0);
        if (do_abort) begin
            check({tag, "_no_done"}, done_cnt, 0);
            check({tag, "_writes"}, write_cnt, stop_at_byte);
        end else begin
            check({tag, "_done_cnt"}, done_cnt, 1);
            check({tag, "_ce_to_done"}, done_at, total);
            check({tag, "_align_seen"}, saw_align, odd);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0; ce = 1'b0; dma_start = 1'b0; dma_page = 8'h00; oam_base = 8'h00;
`ifdef OAM_DMA_ABORT_EN
        dma_abort = 1'b0;
`endif
        for (int i = 0; i < 65536; i++) mem_m[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 256; i++) oam_m[i] = 8'h00;

        repeat (3) @(negedge clk);
        #2;
        check("reset_halt", cpu_halt, 1'b0);
        check("reset_mem_rd", mem_rd, 1'b0);
        check("reset_oam_we", oam_we, 1'b0);
        check("reset_done", dma_done, 1'b0);
        check("reset_mem_addr", mem_addr, 16'h0000);
        check("reset_oam_addr", oam_addr, 8'h00);
        check("reset_oam_din", oam_din, 8'h00);
        check("reset_state", dbg_state, OAM_DMA_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        n_ce = 0;

        // even start, page $02, base 0, ce every third clk
        run_xfer(8'h02, 8'h00, 1'b0, 3, -1, 1'b0, -1, 1'b0, "even");
        check("even_oam0", oam_m[0], mem_m[16'h0200]);
        check("even_oam255", oam_m[255], mem_m[16'h02FF]);

        // odd start visits ALIGN, same data
        run_xfer(8'h02, 8'h00, 1'b1, 2, -1, 1'b0, -1, 1'b0, "odd");
        check("odd_oam128", oam_m[128], mem_m[16'h0280]);

        // base $F0 wraps within OAM
        run_xfer(8'h05, 8'hF0, 1'b0, 0, -1, 1'b0, -1, 1'b0, "base_f0");
        check("base_f0_first_addr", wr_addr[0], 8'hF0);
        check("base_f0_17th_addr", wr_addr[16], 8'h00);
        check("base_f0_last_addr", wr_addr[255], 8'hEF);

        // strobes mid-transfer and on the done cycle are ignored
        run_xfer(8'h07, 8'h10, 1'b1, 0, 50, 1'b1, -1, 1'b0, "restrobe");
        for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b0);
        check("restrobe_no_restart", cpu_halt, 1'b0);
        check("restrobe_single_done", done_cnt, 1);

        // reset at byte 100 drops halt asynchronously
        run_xfer(8'h09, 8'h00, 1'b0, 3, -1, 1'b0, 100, 1'b0, "reset_mid");
        check("reset_mid_writes", write_cnt, 100);
        check("reset_mid_exp_left", exp_q.size(), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        ce = 1'b0;
        #1;
        check("reset_mid_halt_async", cpu_halt, 1'b0);
        check("reset_mid_state", dbg_state, OAM_DMA_IDLE);
        check("reset_mid_oam_we", oam_we, 1'b0);
        in_xfer = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_ce = 0;
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0);
        check("reset_mid_stays_idle", cpu_halt, 1'b0);
        run_xfer(8'h0A, 8'h20, 1'b1, 3, -1, 1'b0, -1, 1'b0, "after_reset");

`ifdef OAM_DMA_ABORT_EN
        for (int i = 0; i < 256; i++) oam_m[i] = 8'hEE;
        run_xfer(8'h0B, 8'h00, 1'b0, 3, -1, 1'b0, 10, 1'b1, "abort");
        check("abort_oam9", oam_m[9], mem_m[16'h0B09]);
        check("abort_oam10_untouched", oam_m[10], 8'hEE);
        check("abort_oam255_untouched", oam_m[255], 8'hEE);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
